// File: rtl/uart_capture.sv
// UART receiver (8N1, mid-bit sampling) with a small escape-based command decoder
// that drives debug/simulation control flags from the received byte stream.
module uart_capture #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RXD,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       FRAME_ERR,
  output logic       DEBUG_TESTER_ENABLE,
  output logic       SIMULATIONEND,
  output logic [7:0] AUXCTRL
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;
  typedef enum logic [1:0] {NORMAL, ESC, AUXLOAD} dec_state_t;

  logic            sync1_reg, sync2_reg;
  rx_state_t       rx_state_reg, rx_state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [2:0]      bit_idx_reg, bit_idx_next;
  logic [7:0]      shift_reg, shift_next;
  logic [7:0]      rx_data_reg, rx_data_next;
  logic            rx_valid_reg, rx_valid_next;
  logic            frame_err_reg, frame_err_next;
  dec_state_t      dec_reg, dec_next;
  logic            dbg_reg, dbg_next;
  logic            simend_reg, simend_next;
  logic [7:0]      aux_reg, aux_next;

  logic rxd_s;
  assign rxd_s = sync2_reg;

  // Synchronizer resets to the idle-high line level so no false start is seen.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= RXD;
      sync2_reg <= sync1_reg;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rx_state_reg  <= IDLE;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      rx_data_reg   <= '0;
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      rx_state_reg  <= rx_state_next;
      cnt_reg       <= cnt_next;
      bit_idx_reg   <= bit_idx_next;
      shift_reg     <= shift_next;
      rx_data_reg   <= rx_data_next;
      rx_valid_reg  <= rx_valid_next;
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    rx_state_next  = rx_state_reg;
    cnt_next       = cnt_reg + 1'b1;
    bit_idx_next   = bit_idx_reg;
    shift_next     = shift_reg;
    rx_data_next   = rx_data_reg;
    rx_valid_next  = 1'b0;
    frame_err_next = 1'b0;
    case (rx_state_reg)
      IDLE: begin
        cnt_next = '0;
        if (!rxd_s) rx_state_next = START;
      end
      START: begin
        // Re-check the line at mid start bit to reject short glitches.
        if (cnt_reg == HALF_LAST) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          rx_state_next = rxd_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_reg == LAST) begin
          cnt_next     = '0;
          shift_next   = {rxd_s, shift_reg[7:1]};
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) rx_state_next = STOP;
        end
      end
      STOP: begin
        if (cnt_reg == LAST) begin
          cnt_next = '0;
          if (rxd_s) begin
            rx_data_next  = shift_reg;
            rx_valid_next = 1'b1;
            rx_state_next = IDLE;
          end else begin
            frame_err_next = 1'b1;
            rx_state_next  = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_next = '0;
        if (rxd_s) rx_state_next = IDLE;
      end
      default: rx_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      dec_reg    <= NORMAL;
      dbg_reg    <= 1'b0;
      simend_reg <= 1'b0;
      aux_reg    <= '0;
    end else begin
      dec_reg    <= dec_next;
      dbg_reg    <= dbg_next;
      simend_reg <= simend_next;
      aux_reg    <= aux_next;
    end
  end

  // Decoder consumes the registered byte during its RX_VALID cycle.
  always_comb begin
    dec_next    = dec_reg;
    dbg_next    = dbg_reg;
    simend_next = simend_reg;
    aux_next    = aux_reg;
    if (rx_valid_reg) begin
      case (dec_reg)
        NORMAL: begin
          if (rx_data_reg == 8'h1B)      dec_next = ESC;
          else if (rx_data_reg == 8'h04) simend_next = 1'b1;
        end
        ESC: begin
          case (rx_data_reg)
            8'h11:   begin dbg_next = 1'b1; dec_next = NORMAL; end
            8'h12:   begin dbg_next = 1'b0; dec_next = NORMAL; end
            8'h13:   dec_next = AUXLOAD;
            8'h1B:   dec_next = ESC;
            default: dec_next = NORMAL;
          endcase
        end
        AUXLOAD: begin
          aux_next = rx_data_reg;
          dec_next = NORMAL;
        end
        default: dec_next = NORMAL;
      endcase
    end
  end

  assign RX_DATA             = rx_data_reg;
  assign RX_VALID            = rx_valid_reg;
  assign FRAME_ERR           = frame_err_reg;
  assign DEBUG_TESTER_ENABLE = dbg_reg;
  assign SIMULATIONEND       = simend_reg;
  assign AUXCTRL             = aux_reg;

endmodule

// File: tb/tb_uart_capture.sv
// Directed bench for uart_capture: frames, command sequences, framing error,
// glitch rejection and mid-frame reset, checked with immediate assertions.
module tb_uart_capture;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       RXD = 1'b1;
  logic [7:0] RX_DATA;
  logic       RX_VALID, FRAME_ERR, DEBUG_TESTER_ENABLE, SIMULATIONEND;
  logic [7:0] AUXCTRL;

  int tests = 0;
  int fails = 0;

  // Monitor state, sampled on the falling edge.
  int       valid_cnt = 0;
  int       ferr_cnt = 0;
  int       both_cnt = 0;
  logic     prev_valid = 1'b0;
  logic [7:0] last_data = 8'h00;
  logic     dbg_at_valid = 1'b0;
  logic     dbg_after = 1'b0;
  logic     simend_after = 1'b0;
  logic [7:0] aux_after = 8'h00;

  uart_capture #(.CLKS_PER_BIT(16)) dut (
    .CLK(CLK), .RESET(RESET), .RXD(RXD),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .FRAME_ERR(FRAME_ERR),
    .DEBUG_TESTER_ENABLE(DEBUG_TESTER_ENABLE), .SIMULATIONEND(SIMULATIONEND),
    .AUXCTRL(AUXCTRL)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (prev_valid) begin
      dbg_after    = DEBUG_TESTER_ENABLE;
      simend_after = SIMULATIONEND;
      aux_after    = AUXCTRL;
    end
    if (RX_VALID) begin
      valid_cnt++;
      last_data    = RX_DATA;
      dbg_at_valid = DEBUG_TESTER_ENABLE;
    end
    if (FRAME_ERR) ferr_cnt++;
    if (RX_VALID && FRAME_ERR) both_cnt++;
    prev_valid = RX_VALID;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold RXD at v for n clocks; returns 1 time unit after a rising edge.
  task automatic drive(input logic v, input int n);
    RXD = v;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive(1'b0, 16);
    for (int i = 0; i < 8; i++) drive(d[i], 16);
    drive(stop, 16);
    drive(1'b1, 16);
    $display("[TB] frame %02h stop=%0b rx_data=%02h valid_cnt=%0d ferr_cnt=%0d",
             d, stop, RX_DATA, valid_cnt, ferr_cnt);
  endtask

  initial begin
    int v0, f0;
    logic [7:0] aa;
    aa = 8'hAA;

    repeat (3) @(posedge CLK);
    #1;
    check("reset_rx_data", {24'd0, RX_DATA}, 32'h00);
    check("reset_valid", {31'd0, RX_VALID}, 32'd0);
    check("reset_ferr", {31'd0, FRAME_ERR}, 32'd0);
    check("reset_dbg", {31'd0, DEBUG_TESTER_ENABLE}, 32'd0);
    check("reset_simend", {31'd0, SIMULATIONEND}, 32'd0);
    check("reset_aux", {24'd0, AUXCTRL}, 32'h00);
    RESET = 1'b0;
    drive(1'b1, 8);

    // Plain byte
    send_frame(8'h41, 1'b1);
    check("byte41_valid_pulses", valid_cnt, 1);
    check("byte41_data", {24'd0, last_data}, 32'h41);
    check("byte41_rx_data", {24'd0, RX_DATA}, 32'h41);
    check("byte41_no_ferr", ferr_cnt, 0);

    // Debug enable with 1-cycle latency, then disable
    send_frame(8'h1B, 1'b1);
    send_frame(8'h11, 1'b1);
    check("dbg_set_at_valid", {31'd0, dbg_at_valid}, 32'd0);
    check("dbg_set_after", {31'd0, dbg_after}, 32'd1);
    check("dbg_set_level", {31'd0, DEBUG_TESTER_ENABLE}, 32'd1);
    send_frame(8'h1B, 1'b1);
    send_frame(8'h12, 1'b1);
    check("dbg_clr_after", {31'd0, dbg_after}, 32'd0);
    check("dbg_clr_level", {31'd0, DEBUG_TESTER_ENABLE}, 32'd0);

    // AUXCTRL loads, including a byte that would otherwise end simulation
    send_frame(8'h1B, 1'b1);
    send_frame(8'h13, 1'b1);
    send_frame(8'hA5, 1'b1);
    check("aux_a5_after", {24'd0, aux_after}, 32'hA5);
    check("aux_a5", {24'd0, AUXCTRL}, 32'hA5);
    send_frame(8'h1B, 1'b1);
    send_frame(8'h13, 1'b1);
    send_frame(8'h04, 1'b1);
    check("aux_04", {24'd0, AUXCTRL}, 32'h04);
    check("aux_04_no_simend", {31'd0, SIMULATIONEND}, 32'd0);

    // Sticky end-of-simulation flag
    send_frame(8'h04, 1'b1);
    check("simend_after", {31'd0, simend_after}, 32'd1);
    send_frame(8'h1B, 1'b1);
    send_frame(8'h12, 1'b1);
    check("simend_sticky", {31'd0, SIMULATIONEND}, 32'd1);
    check("aux_unchanged", {24'd0, AUXCTRL}, 32'h04);

    // Framing error then recovery
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(8'h55, 1'b0);
    check("ferr_pulse", ferr_cnt - f0, 1);
    check("ferr_no_valid", valid_cnt - v0, 0);
    check("ferr_rx_data_kept", {24'd0, RX_DATA}, 32'h12);
    send_frame(8'h33, 1'b1);
    check("recover_33", {24'd0, last_data}, 32'h33);
    check("recover_valid", valid_cnt - v0, 1);

    // Short low glitch must be ignored
    v0 = valid_cnt;
    f0 = ferr_cnt;
    drive(1'b0, 4);
    drive(1'b1, 200);
    $display("[TB] glitch 4 cycles valid_cnt=%0d ferr_cnt=%0d", valid_cnt, ferr_cnt);
    check("glitch_no_valid", valid_cnt - v0, 0);
    check("glitch_no_ferr", ferr_cnt - f0, 0);

    // Mid-frame asynchronous reset
    send_frame(8'h1B, 1'b1);
    send_frame(8'h11, 1'b1);
    check("pre_reset_dbg", {31'd0, DEBUG_TESTER_ENABLE}, 32'd1);
    v0 = valid_cnt;
    drive(1'b0, 16);
    for (int i = 0; i < 3; i++) drive(aa[i], 16);
    #2 RESET = 1'b1;
    #1;
    $display("[TB] reset mid-frame rx_data=%02h dbg=%0b simend=%0b aux=%02h",
             RX_DATA, DEBUG_TESTER_ENABLE, SIMULATIONEND, AUXCTRL);
    check("rst_rx_data", {24'd0, RX_DATA}, 32'h00);
    check("rst_valid", {31'd0, RX_VALID}, 32'd0);
    check("rst_ferr", {31'd0, FRAME_ERR}, 32'd0);
    check("rst_dbg", {31'd0, DEBUG_TESTER_ENABLE}, 32'd0);
    check("rst_simend", {31'd0, SIMULATIONEND}, 32'd0);
    check("rst_aux", {24'd0, AUXCTRL}, 32'h00);
    RXD = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    drive(1'b1, 16);
    check("rst_partial_discarded", valid_cnt - v0, 0);
    send_frame(8'hC3, 1'b1);
    check("post_rst_c3", {24'd0, last_data}, 32'hC3);
    check("post_rst_valid", valid_cnt - v0, 1);
    check("never_both", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    fails++;
    $display("FAIL timeout reached observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
